// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency mult/div with shadow HI/LO,
// mthi/mtlo writes, and pipeline stall generation for dependent D-stage ops.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        move_to,
    input  logic [2:0]  sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        req,
    input  logic        d_uses_mdu,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [31:0]     r_hi, r_lo, r_shi, r_slo;
    logic            r_dz;

    logic            w_go, w_mt, w_done, w_sgn;
    logic [31:0]     w_ua, w_ub, w_ubs, w_uq, w_ur, w_q, w_r;
    logic [63:0]     w_ax, w_bx, w_prod;

    // sel[0] clear selects the signed flavour for both mult and div
    assign w_sgn  = ~sel[0];
    assign w_go   = (r_state == IDLE) & start & ~req & ~sel[2];
    assign w_mt   = (r_state == IDLE) & move_to & ~start & ~req & (sel == 3'd4 | sel == 3'd5);
    assign w_done = (r_state != IDLE) & (r_cnt == CW'(1));

    assign w_ax   = {{32{w_sgn & a[31]}}, a};
    assign w_bx   = {{32{w_sgn & b[31]}}, b};
    assign w_prod = w_ax * w_bx;

    // Divide magnitudes, then restore signs; 0x80000000/-1 wraps to 0x80000000
    assign w_ua  = (w_sgn & a[31]) ? -a : a;
    assign w_ub  = (w_sgn & b[31]) ? -b : b;
    assign w_ubs = (b == 32'd0) ? 32'd1 : w_ub;
    assign w_uq  = w_ua / w_ubs;
    assign w_ur  = w_ua % w_ubs;
    assign w_q   = (w_sgn & (a[31] ^ b[31])) ? -w_uq : w_uq;
    assign w_r   = (w_sgn & a[31]) ? -w_ur : w_ur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    w_state_nxt = sel[1] ? DIV : MULT;
                    w_cnt_nxt   = sel[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            MULT, DIV: begin
                w_cnt_nxt = r_cnt - CW'(1);
                if (w_done) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_shi <= '0;
            r_slo <= '0;
            r_dz  <= 1'b0;
        end else begin
            if (w_go) begin
                if (sel[1]) begin
                    r_shi <= w_r;
                    r_slo <= w_q;
                    r_dz  <= (b == 32'd0);
                end else begin
                    r_shi <= w_prod[63:32];
                    r_slo <= w_prod[31:0];
                    r_dz  <= 1'b0;
                end
            end
            if (w_done && !r_dz) begin
                r_hi <= r_shi;
                r_lo <= r_slo;
            end
            if (w_mt) begin
                if (sel[0]) r_lo <= a;
                else        r_hi <= a;
            end
        end
    end

    assign busy  = (r_state != IDLE);
    assign stall = d_uses_mdu & (busy | start);
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign rdata = (sel == 3'd7) ? r_lo : r_hi;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed + scoreboard bench for mdu_ctrl: latency, results, mt*, req, reset.
module tb_mdu_ctrl;

    logic        clk, rst, start, move_to, req, d_uses_mdu;
    logic [2:0]  sel;
    logic [31:0] a, b;
    logic        busy, stall;
    logic [31:0] hi, lo, rdata;

    typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start), .move_to(move_to), .sel(sel),
        .a(a), .b(b), .req(req), .d_uses_mdu(d_uses_mdu),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] h0, input logic [31:0] l0);
        exp_t e;
        longint p, q, r;
        longint unsigned pu;
        e.hi = h0;
        e.lo = l0;
        case (s)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            3'd1: begin
                pu = longint'({32'd0, x}) * longint'({32'd0, y});
                e.hi = pu[63:32]; e.lo = pu[31:0];
            end
            3'd2: if (y != 0) begin
                q = longint'($signed(x)) / longint'($signed(y));
                r = longint'($signed(x)) % longint'($signed(y));
                e.hi = r[31:0]; e.lo = q[31:0];
            end
            3'd3: if (y != 0) begin
                e.hi = x % y; e.lo = x / y;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y,
                          input int n, input bit du, input string tag);
        exp_t e;
        int cnt;
        sb.push_back(model(s, x, y, m_hi, m_lo));
        sel = s; a = x; b = y; start = 1'b1; d_uses_mdu = du;
        #1;
        if (du) chk({tag, "_stall_start"}, {31'd0, stall}, 32'd1);
        tick();
        start = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < n + 5) begin
            if (du) chk({tag, "_stall_busy"}, {31'd0, stall}, 32'd1);
            cnt++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
        if (du) chk({tag, "_stall_after"}, {31'd0, stall}, 32'd0);
        e = sb.pop_front();
        chk({tag, "_hi"}, hi, e.hi);
        chk({tag, "_lo"}, lo, e.lo);
        m_hi = e.hi; m_lo = e.lo;
        sel = 3'd7; #1 chk({tag, "_rdata_lo"}, rdata, e.lo);
        sel = 3'd6; #1 chk({tag, "_rdata_hi"}, rdata, e.hi);
        d_uses_mdu = 1'b0;
    endtask

    task automatic move(input logic [2:0] s, input logic [31:0] x, input logic r, input string tag);
        sel = s; a = x; move_to = 1'b1; req = r;
        tick();
        move_to = 1'b0; req = 1'b0;
        if (!r) begin
            if (s == 3'd4) m_hi = x;
            else           m_lo = x;
        end
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    initial begin
        int cnt;
        logic [2:0]  rs;
        logic [31:0] rx, ry;
        rst = 1'b1; start = 1'b0; move_to = 1'b0; req = 1'b0; d_uses_mdu = 1'b0;
        sel = 3'd0; a = '0; b = '0;
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        #1 rst = 1'b0;
        tick();

        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, "mult_neg1x2");
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, "multu_maxx2");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10, 1'b1, "div_m7by2");

        move(3'd4, 32'h11, 1'b0, "mthi_11");
        move(3'd5, 32'h22, 1'b0, "mtlo_22");
        run_op(3'd3, 32'd5, 32'd0, 10, 1'b0, "divu_by0");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, "div_ovf");
        run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 10, 1'b0, "div_7bym2");

        // start under req is cancelled
        sel = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1; req = 1'b1;
        tick();
        start = 1'b0; req = 1'b0;
        chk("req_start_busy", {31'd0, busy}, 32'd0);
        chk("req_start_hi", hi, m_hi);
        chk("req_start_lo", lo, m_lo);
        move(3'd4, 32'h1234, 1'b1, "req_mthi");
        move(3'd5, 32'h1234, 1'b0, "mtlo_1234");

        // start and move_to while busy are ignored
        sb.push_back(model(3'd1, 32'd3, 32'd4, m_hi, m_lo));
        sel = 3'd1; a = 32'd3; b = 32'd4; start = 1'b1;
        tick();
        sel = 3'd2; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0; move_to = 1'b1; sel = 3'd5; a = 32'hDEAD;
        tick();
        move_to = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 10) begin cnt++; tick(); end
        begin
            exp_t e;
            e = sb.pop_front();
            chk("busy_ign_hi", hi, e.hi);
            chk("busy_ign_lo", lo, e.lo);
            m_hi = e.hi; m_lo = e.lo;
        end
        tick();
        chk("busy_ign_idle", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            rs = 3'($urandom_range(0, 3));
            rx = $urandom;
            ry = (i == 4) ? 32'd0 : $urandom;
            run_op(rs, rx, ry, (rs < 3'd2) ? 5 : 10, 1'b0, "rnd");
        end

        // reset mid-cycle during busy cycle 4 of a div
        sel = 3'd2; a = 32'd100; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        #1 rst = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (12) tick();
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        chk("rst_after_hi", hi, 32'd0);
        chk("rst_after_lo", lo, 32'd0);

        run_op(3'd1, 32'd6, 32'd7, 5, 1'b0, "post_rst_multu");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
